// File: rtl/mem_port_arbiter3_pkg.sv
// Shared encodings for the three-way memory port arbiter: mux selects, FSM states,
// requester indices and the modulo-3 index step.
package mem_port_arbiter3_pkg;

  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b10;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int unsigned IFETCH = 0;
  localparam int unsigned LSU    = 1;
  localparam int unsigned DBG    = 2;

  // Step a requester index modulo 3; the unused encoding folds back to requester 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] nxt;
    unique case (idx)
      SEL_REQ0: nxt = SEL_REQ1;
      SEL_REQ1: nxt = SEL_REQ2;
      default:  nxt = SEL_REQ0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational rotate-priority encoder over three requesters: the first set bit
// found searching ptr, ptr+1, ptr+2 (mod 3) wins.
module rr_pick3
  import mem_port_arbiter3_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0 = (ptr == 2'b11) ? SEL_REQ0 : ptr;
    c1 = next_idx(c0);
    c2 = next_idx(c1);
    // Later assignments override earlier ones, so the candidate nearest ptr wins.
    idx = SEL_REQ0;
    if (req[c2]) idx = c2;
    if (req[c1]) idx = c1;
    if (req[c0]) idx = c0;
  end

  assign valid = |req;

endmodule

// File: rtl/mem_port_arbiter3.sv
// Round-robin owner of the shared 32-bit memory port: fetch, load/store and debug/DMA,
// with locked back-to-back transfers up to a hold cap and a no-response timeout.
module mem_port_arbiter3
  import mem_port_arbiter3_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CW       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] lock,
  input  logic       mem_ready,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       mem_valid,
  output logic [2:0] done,
  output logic       timeout
);

  logic          state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;

  logic          pick_valid;
  logic [1:0]    pick_idx;
  logic          release_port;

  rr_pick3 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wait_d       = wait_q;
    hold_d       = hold_q;
    gnt_d        = gnt_q;
    sel_d        = sel_q;
    valid_d      = valid_q;
    timeout_d    = 1'b0;
    release_port = 1'b0;

    if (state_q == ST_IDLE) begin
      if (pick_valid) begin
        state_d = ST_GRANT;
        gnt_d   = 3'b001 << pick_idx;
        sel_d   = pick_idx;
        valid_d = 1'b1;
        wait_d  = '0;
        hold_d  = '0;
      end
    end else begin
      // Abort beats completion beats timeout; completion also wins over a same-cycle expiry.
      if (!req[sel_q]) begin
        release_port = 1'b1;
      end else if (mem_ready) begin
        if (lock[sel_q] && (hold_q < CW'(MAX_HOLD - 1))) begin
          hold_d = hold_q + 1'b1;
          wait_d = '0;
        end else begin
          release_port = 1'b1;
        end
      end else if (wait_q == CW'(WAIT_MAX - 1)) begin
        release_port = 1'b1;
        timeout_d    = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end

      if (release_port) begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
        sel_d   = SEL_REQ0;
        valid_d = 1'b0;
        ptr_d   = next_idx(sel_q);
        wait_d  = '0;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= SEL_REQ0;
      wait_q    <= '0;
      hold_q    <= '0;
      gnt_q     <= 3'b000;
      sel_q     <= SEL_REQ0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wait_q    <= wait_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign mem_valid = valid_q;
  assign timeout   = timeout_q;
  assign done      = gnt_q & {3{mem_ready & valid_q}};

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Self-checking bench for mem_port_arbiter3: directed scenarios with a queue of
// expected grants/done values popped as the DUT produces them.
module tb_mem_port_arbiter3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [2:0] lock;
  logic       mem_ready;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       mem_valid;
  logic [2:0] done;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  mem_port_arbiter3 #(
    .MAX_HOLD (4),
    .WAIT_MAX (16),
    .CW       (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .mem_ready (mem_ready),
    .gnt       (gnt),
    .sel       (sel),
    .mem_valid (mem_valid),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled 1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b000; lock = 3'b000; mem_ready = 1'b0;
    step(); step();
    #1;
    checks++;
    if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    checks++;
    if (sel !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b want 00", sel); end
    checks++;
    if (mem_valid !== 1'b0 || timeout !== 1'b0 || done !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b timeout=%b done=%b want 0 0 000",
               mem_valid, timeout, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    req = 3'b010;
    step(); #1;
    checks++;
    if (gnt !== 3'b010 || sel !== 2'b01 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b sel=%b valid=%b want 010 01 1", gnt, sel, mem_valid);
    end
    step(); step(); step();
    mem_ready = 1'b1; #1;
    checks++;
    if (done !== 3'b010) begin errors++; $display("FAIL single_done: got %b want 010", done); end
    step();
    req = 3'b000; mem_ready = 1'b0; #1;
    checks++;
    if (gnt !== 3'b000 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got gnt=%b valid=%b want 000 0", gnt, mem_valid);
    end
    // ptr should now sit on requester 2
    req = 3'b111;
    step(); #1;
    checks++;
    if (gnt !== 3'b100) begin errors++; $display("FAIL single_ptr2: got %b want 100", gnt); end
    req = 3'b000;
    step(); #1;
    checks++;
    if (gnt !== 3'b000) begin errors++; $display("FAIL single_abort_idle: got %b want 000", gnt); end
  endtask

  task automatic test_round_robin();
    logic [2:0] prev_gnt;
    logic [2:0] exp;
    exp_q.delete();
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    exp_q.push_back(3'b100); exp_q.push_back(3'b001);
    prev_gnt = 3'b000;
    req = 3'b111; mem_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      step(); #1;
      if (gnt !== 3'b000) begin
        exp = exp_q.pop_front();
        checks++;
        if (gnt !== exp || done !== exp) begin
          errors++;
          $display("FAIL rr_order: got gnt=%b done=%b want %b", gnt, done, exp);
        end
        checks++;
        if (prev_gnt !== 3'b000) begin
          errors++;
          $display("FAIL rr_gap: got previous gnt=%b want 000", prev_gnt);
        end
      end
      prev_gnt = gnt;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_budget: got %0d grants pending want 0", exp_q.size());
    end
    req = 3'b000; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_lock();
    logic [2:0] exp;
    reset = 1'b1; req = 3'b000; mem_ready = 1'b0;
    step();
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(3'b001);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b010);
    req = 3'b011; lock = 3'b001; mem_ready = 1'b1;
    while (exp_q.size() > 0) begin
      step(); #1;
      exp = exp_q.pop_front();
      checks++;
      if (gnt !== exp || done !== exp) begin
        errors++;
        $display("FAIL lock_seq: got gnt=%b done=%b want %b", gnt, done, exp);
      end
    end
    req = 3'b000; lock = 3'b000; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int vcnt = 0;
    int tcnt = 0;
    int dcnt = 0;
    bit fell = 1'b0;
    req = 3'b100; mem_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(); #1;
      if (timeout === 1'b1) tcnt++;
      if (done !== 3'b000) dcnt++;
      if (mem_valid === 1'b1) vcnt++;
      else begin
        fell = 1'b1;
        break;
      end
    end
    checks++;
    if (!fell) begin errors++; $display("FAIL to_release: got valid stuck high want release"); end
    checks++;
    if (vcnt != 16) begin errors++; $display("FAIL to_valid_len: got %0d want 16", vcnt); end
    checks++;
    if (tcnt != 1 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse: got count=%0d now=%b want 1 1", tcnt, timeout);
    end
    checks++;
    if (dcnt != 0) begin errors++; $display("FAIL to_no_done: got %0d want 0", dcnt); end
    req = 3'b111;
    step(); #1;
    checks++;
    if (gnt !== 3'b001 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_next_winner: got gnt=%b timeout=%b want 001 0", gnt, timeout);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_abort();
    req = 3'b010; mem_ready = 1'b0;
    step(); #1;
    checks++;
    if (gnt !== 3'b010) begin errors++; $display("FAIL abort_grant: got %b want 010", gnt); end
    step();
    req = 3'b000; #1;
    checks++;
    if (done !== 3'b000) begin errors++; $display("FAIL abort_no_done: got %b want 000", done); end
    step(); #1;
    checks++;
    if (gnt !== 3'b000 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got gnt=%b valid=%b want 000 0", gnt, mem_valid);
    end
    req = 3'b111;
    step(); #1;
    checks++;
    if (gnt !== 3'b100) begin errors++; $display("FAIL abort_ptr2: got %b want 100", gnt); end
    req = 3'b000;
    step();
  endtask

  task automatic test_ready_at_limit();
    req = 3'b001; mem_ready = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    mem_ready = 1'b1; #1;
    checks++;
    if (done !== 3'b001) begin errors++; $display("FAIL limit_done: got %b want 001", done); end
    step();
    req = 3'b000; mem_ready = 1'b0; #1;
    checks++;
    if (timeout !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL limit_no_timeout: got timeout=%b valid=%b want 0 0", timeout, mem_valid);
    end
  endtask

  task automatic test_reset_in_grant();
    req = 3'b100; mem_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step(); #1;
    checks++;
    if (gnt !== 3'b000 || sel !== 2'b00 || mem_valid !== 1'b0 || timeout !== 1'b0 ||
        done !== 3'b000) begin
      errors++;
      $display("FAIL rst_grant_outputs: got gnt=%b sel=%b valid=%b timeout=%b done=%b want zeros",
               gnt, sel, mem_valid, timeout, done);
    end
    reset = 1'b0;
    step(); #1;
    checks++;
    if (gnt !== 3'b100) begin errors++; $display("FAIL rst_grant_regrant: got %b want 100", gnt); end
    req = 3'b000;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; req = 3'b111;
    step(); #1;
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL rst_ptr_zero: got %b want 001", gnt); end
    req = 3'b000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_abort();
    test_ready_at_limit();
    test_reset_in_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter3.md
Name: mem_port_arbiter3

Overview:
- Round-robin arbiter sharing the single 32-bit memory port between three requesters: 0 = instruction fetch, 1 = load/store unit, 2 = debug/DMA.
- Generates the 2-bit select for the 3:1 address/wdata/control muxes in front of the port, plus per-requester grant and done.
- Supports locked back-to-back transfers with a hold cap, and a timeout release when memory never responds.

Parameters:
- MAX_HOLD, 4: maximum consecutive transfers one locked owner may take before it must release; must be ≥1.
- WAIT_MAX, 16: cycles mem_valid may stay high without mem_ready before a timeout release; must be ≥2.
- CW, 5: width of the wait and hold counters; must satisfy 2^CW > max(WAIT_MAX, MAX_HOLD).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  3  request per requester; held high until done or until abandoning.
- lock  in  3  per-requester request to keep the port after its current transfer.
- mem_ready  in  1  memory completes the current transfer this cycle.
- gnt  out  3  one-hot grant, registered.
- sel  out  2  mux select, registered: 00 = req0, 01 = req1, 10 = req2; 11 is never driven.
- mem_valid  out  1  transfer in progress to memory, registered.
- done  out  3  combinational: gnt & {3{mem_ready & mem_valid}}.
- timeout  out  1  registered one-cycle pulse after a WAIT_MAX expiry.

Behaviour:
- Reset values: gnt = 000, sel = 00, mem_valid = 0, timeout = 0, state = IDLE, ptr = 0, wait_cnt = 0, hold_cnt = 0.
- Reset takes effect on the next edge from any state and abandons any in-flight transfer without asserting done.
- States: IDLE and GRANT.
- IDLE, req == 000: stay in IDLE with gnt = 000 and sel = 00.
- IDLE, any req bit high:
  - Winner is the first set bit searching ptr, ptr+1, ptr+2 (mod 3).
  - Next edge: gnt = onehot(winner), sel = winner, mem_valid = 1, state = GRANT, wait_cnt = 0, hold_cnt = 0.
  - Latency from req seen in IDLE to gnt is 1 cycle.
- GRANT, priority order of checks each cycle (owner = index held in sel):
  - a) Abort: req[owner] = 0. Next edge → IDLE, gnt = 0, mem_valid = 0, ptr = owner+1 mod 3. No done is asserted.
  - b) Completion: mem_ready = 1, so done[owner] = 1 this cycle.
    - If lock[owner] & req[owner] & (hold_cnt < MAX_HOLD-1): stay in GRANT, hold_cnt + 1, wait_cnt = 0, with no idle gap.
    - Otherwise: → IDLE, gnt = 0, mem_valid = 0, ptr = owner+1 mod 3.
  - c) Timeout: wait_cnt == WAIT_MAX-1 with no mem_ready. Next edge → IDLE, ptr = owner+1 mod 3, timeout = 1 for one cycle. No done is asserted.
  - d) Otherwise: wait_cnt + 1.
- Every release passes through one IDLE cycle (bus turnaround), so there is a minimum 1-cycle gap between different owners.
- Because ptr advances past the releasing owner, each requester wins within 2 grants of any other.
- ptr takes values 0..2 only and wraps 2 → 0.
- Simultaneous events:
  - mem_ready in the same cycle as wait_cnt == WAIT_MAX-1: completion wins and no timeout pulse is issued.
  - req drop in the same cycle as mem_ready: abort wins and done is still visible combinationally. Requesters must not rely on done after dropping req.
- Changes to lock on non-owners are ignored. lock is sampled only at the owner's completion.

Decomposition:
- Shared package holds:
  - sel encodings SEL_REQ0 = 2'b00, SEL_REQ1 = 2'b01, SEL_REQ2 = 2'b10.
  - state encoding ST_IDLE / ST_GRANT.
  - requester index constants for IFETCH, LSU, DBG.
- One natural sub-module: rr_pick3, a combinational rotate-priority encoder. Inputs are req[2:0] and ptr[1:0]; outputs are valid and idx[1:0]. It is reusable for other shared resources.

Test Plan:
- Reset then req = 010, mem_ready high 3 cycles after gnt → gnt = 010 and sel = 01 one cycle after req; done = 010 on the ready cycle; IDLE next; ptr = 2.
- Reset then req = 111 held, mem_ready = 1 every GRANT cycle → grants in order 001, 010, 100, 001, each separated by one IDLE cycle.
- req = 001 with lock = 001, MAX_HOLD = 4, mem_ready every cycle, req1 also pending → 4 consecutive done[0] pulses with no gap, then IDLE, then gnt = 010.
- req = 100, mem_ready never asserted, WAIT_MAX = 16 → mem_valid high exactly 16 cycles; timeout pulses once; no done; next winner search starts at 0.
- Owner req1 drops req mid-transfer (cycle 2 of GRANT) → gnt = 000 next edge, no done[1], ptr = 2.
- Assert reset in GRANT with wait_cnt = 5 → next edge all outputs at reset values and ptr = 0; with req = 100 afterwards, grant goes to 100 one cycle after reset deasserts.
